// File: rtl/spi_arbiter_ctrl.sv
// Round-robin arbiter that shares one SPI master between N_REQ requesters.
// Latches the winner's byte/mode/slave, drives slave select, and reports completion or timeout.
module spi_arbiter_ctrl #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned N_SS    = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned GAP_CYC = 4,
  localparam int unsigned SlvW   = (N_SS > 1) ? $clog2(N_SS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [8*N_REQ-1:0]      req_data,
  input  logic [2*N_REQ-1:0]      req_mode,
  input  logic [N_REQ*SlvW-1:0]   req_slave,
  output logic [N_REQ-1:0]        ack,
  output logic [7:0]              rsp_data,
  output logic                    rsp_err,
  output logic                    spi_start,
  output logic [7:0]              spi_data,
  output logic                    spi_ckp,
  output logic                    spi_cph,
  input  logic                    spi_done,
  input  logic [7:0]              spi_rx,
  output logic [N_SS-1:0]         ss_n
);

  localparam int unsigned IdxW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntMax  = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned TmoLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int unsigned GapLast = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;

  typedef enum logic [2:0] {StIdle, StGrant, StStart, StBusy, StResp, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [7:0]        data_q, data_d;
  logic              ckp_q, ckp_d;
  logic              cph_q, cph_d;
  logic [SlvW-1:0]   slv_q, slv_d;
  logic              slv_ok_q, slv_ok_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              rr_found;
  logic [IdxW-1:0]   rr_win;
  int unsigned       rr_idx;
  logic [SlvW-1:0]   slv_sel;

  // Round-robin search starting one past the previous winner.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    rr_idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rr_idx = (32'(last_q) + 1 + k) % N_REQ;
      if (!rr_found && req[rr_idx[IdxW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx[IdxW-1:0];
      end
    end
  end

  assign slv_sel = req_slave[SlvW*rr_win +: SlvW];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      last_q     <= IdxW'(N_REQ - 1);
      win_q      <= '0;
      data_q     <= '0;
      ckp_q      <= 1'b0;
      cph_q      <= 1'b0;
      slv_q      <= '0;
      slv_ok_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      win_q      <= win_d;
      data_q     <= data_d;
      ckp_q      <= ckp_d;
      cph_q      <= cph_d;
      slv_q      <= slv_d;
      slv_ok_q   <= slv_ok_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    win_d      = win_q;
    data_d     = data_q;
    ckp_d      = ckp_q;
    cph_d      = cph_q;
    slv_d      = slv_q;
    slv_ok_d   = slv_ok_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (|req) state_d = StGrant;
      end
      StGrant: begin
        if (rr_found) begin
          win_d    = rr_win;
          data_d   = req_data[8*rr_win +: 8];
          ckp_d    = req_mode[2*rr_win + 1];
          cph_d    = req_mode[2*rr_win];
          slv_d    = slv_sel;
          slv_ok_d = (32'(slv_sel) < N_SS);
          state_d  = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        cnt_d = '0;
        if (slv_ok_q) begin
          state_d = StBusy;
        end else begin
          // Unreachable slave: skip the transfer and report an error.
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end
      StBusy: begin
        if (spi_done) begin
          rsp_data_d = spi_rx;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else if (cnt_q == CntW'(TmoLast)) begin
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        last_d  = win_q;
        cnt_d   = '0;
        state_d = (GAP_CYC == 0) ? StIdle : StGap;
      end
      StGap: begin
        if (cnt_q == CntW'(GapLast)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ack       = '0;
    spi_start = 1'b0;
    ss_n      = '1;
    unique case (state_q)
      StStart: begin
        if (slv_ok_q) begin
          spi_start   = 1'b1;
          ss_n[slv_q] = 1'b0;
        end
      end
      StBusy: begin
        if (slv_ok_q) ss_n[slv_q] = 1'b0;
      end
      StResp:  ack[win_q] = 1'b1;
      default: ;
    endcase
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign spi_data = data_q;
  assign spi_ckp  = ckp_q;
  assign spi_cph  = cph_q;

  a_ss_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(~ss_n));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(ack));

endmodule

// File: tb/tb_spi_arbiter_ctrl.sv
// Directed bench for spi_arbiter_ctrl: single transfer, timeout, round-robin contention,
// reset abort, unreachable slave and stray completion pulses.
module tb_spi_arbiter_ctrl;

  localparam int unsigned NReq = 4;
  localparam int unsigned Tmo  = 8;
  localparam int unsigned Gap  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [31:0]     req_data;
  logic [7:0]      req_mode;
  logic [3:0]      req_slave;
  logic [3:0]      ack;
  logic [7:0]      rsp_data;
  logic            rsp_err;
  logic            spi_start;
  logic [7:0]      spi_data;
  logic            spi_ckp;
  logic            spi_cph;
  logic            spi_done;
  logic [7:0]      spi_rx;
  logic [1:0]      ss_n;

  // Second instance with three slaves so index 3 is representable but unreachable.
  logic [3:0]      req2;
  logic [7:0]      req_slave2;
  logic [3:0]      ack2;
  logic [7:0]      rsp_data2;
  logic            rsp_err2;
  logic            spi_start2;
  logic [7:0]      spi_data2;
  logic            spi_ckp2;
  logic            spi_cph2;
  logic [2:0]      ss_n2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_arbiter_ctrl #(.N_REQ(NReq), .N_SS(2), .TIMEOUT(Tmo), .GAP_CYC(Gap)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
    .req_slave(req_slave), .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .spi_start(spi_start), .spi_data(spi_data), .spi_ckp(spi_ckp), .spi_cph(spi_cph),
    .spi_done(spi_done), .spi_rx(spi_rx), .ss_n(ss_n)
  );

  spi_arbiter_ctrl #(.N_REQ(NReq), .N_SS(3), .TIMEOUT(Tmo), .GAP_CYC(Gap)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .req_data(req_data), .req_mode(req_mode),
    .req_slave(req_slave2), .ack(ack2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .spi_start(spi_start2), .spi_data(spi_data2), .spi_ckp(spi_ckp2), .spi_cph(spi_cph2),
    .spi_done(spi_done), .spi_rx(spi_rx), .ss_n(ss_n2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; req = '0; req2 = '0; spi_done = 1'b0; spi_rx = '0;
    tick; tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0000", ack); end
    checks++; if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL reset_rsp got %h/%b exp 00/0", rsp_data, rsp_err); end
    checks++; if (spi_start !== 1'b0 || spi_data !== 8'h00 || {spi_ckp, spi_cph} !== 2'b00) begin
      errors++; $display("FAIL reset_spi got %b %h %b%b exp 0 00 00", spi_start, spi_data,
                         spi_ckp, spi_cph); end
    checks++; if (ss_n !== 2'b11 || ss_n2 !== 3'b111) begin errors++;
      $display("FAIL reset_ss_n got %b/%b exp 11/111", ss_n, ss_n2); end
    rst = 1'b1;
  endtask

  task automatic test_single;
    do_reset;
    req_data[15:8] = 8'hA5; req_mode[3:2] = 2'b01; req_slave[1] = 1'b1; req = 4'b0010;
    tick;
    checks++; if (spi_start !== 1'b0 || ss_n !== 2'b11) begin errors++;
      $display("FAIL single_grant got start=%b ss_n=%b exp 0 11", spi_start, ss_n); end
    tick;
    checks++; if (spi_start !== 1'b1) begin errors++;
      $display("FAIL single_latency got start=%b exp 1", spi_start); end
    checks++; if (spi_data !== 8'hA5 || {spi_ckp, spi_cph} !== 2'b01 || ss_n !== 2'b01) begin
      errors++; $display("FAIL single_start got %h %b%b %b exp a5 01 01", spi_data, spi_ckp,
                         spi_cph, ss_n); end
    // Requester inputs change mid-transfer; latched values must not move.
    req_data[15:8] = 8'h00; req_mode[3:2] = 2'b10;
    tick;
    checks++; if (spi_start !== 1'b0 || spi_data !== 8'hA5 || {spi_ckp, spi_cph} !== 2'b01 ||
                  ss_n !== 2'b01) begin errors++;
      $display("FAIL single_busy_stable got %b %h %b%b %b exp 0 a5 01 01", spi_start, spi_data,
               spi_ckp, spi_cph, ss_n); end
    spi_done = 1'b1; spi_rx = 8'h3C;
    tick;
    spi_done = 1'b0;
    checks++; if (ack !== 4'b0010 || rsp_data !== 8'h3C || rsp_err !== 1'b0 || ss_n !== 2'b11)
    begin errors++; $display("FAIL single_ack got %b %h %b %b exp 0010 3c 0 11", ack, rsp_data,
                             rsp_err, ss_n); end
    req = 4'b0;
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL single_ack_pulse got %b exp 0000",
                                                         ack); end
    repeat (4) tick;
  endtask

  task automatic test_timeout;
    int bad;
    bad = 0;
    req_data[7:0] = 8'h55; req_mode[1:0] = 2'b10; req_slave[0] = 1'b0; req = 4'b0001;
    tick; tick;
    checks++; if (ss_n !== 2'b10 || spi_data !== 8'h55 || {spi_ckp, spi_cph} !== 2'b10) begin
      errors++; $display("FAIL tmo_start got %b %h %b%b exp 10 55 10", ss_n, spi_data, spi_ckp,
                         spi_cph); end
    for (int i = 0; i < int'(Tmo); i++) begin
      tick;
      if (ack !== 4'b0 || ss_n !== 2'b10) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tmo_busy_hold got %0d bad exp 0", bad);
    end
    tick;
    checks++; if (ack !== 4'b0001 || rsp_err !== 1'b1 || rsp_data !== 8'h00 || ss_n !== 2'b11)
    begin errors++; $display("FAIL tmo_ack got %b %b %h %b exp 0001 1 00 11", ack, rsp_err,
                             rsp_data, ss_n); end
    req = 4'b0;
    repeat (5) tick;
  endtask

  task automatic test_timeout_edge;
    req = 4'b0001;
    tick; tick;
    repeat (Tmo) tick;
    spi_done = 1'b1; spi_rx = 8'h77;
    tick;
    spi_done = 1'b0;
    checks++; if (ack !== 4'b0001 || rsp_err !== 1'b0 || rsp_data !== 8'h77) begin errors++;
      $display("FAIL tmo_edge got %b %b %h exp 0001 0 77", ack, rsp_err, rsp_data); end
    req = 4'b0;
    repeat (5) tick;
  endtask

  task automatic test_contention;
    logic [1:0] exp_ss;
    int exp, hi;
    bit seen;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      req_data[8*i +: 8] = 8'h10 + 8'(i);
      req_mode[2*i +: 2] = 2'(i);
      req_slave[i]       = i[0];
    end
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp = n % 4;
      seen = 1'b0; hi = 0;
      for (int c = 0; c < 30 && !seen; c++) begin
        tick;
        if (spi_start === 1'b1) seen = 1'b1;
        else if (ss_n === 2'b11) hi++;
      end
      checks++; if (!seen) begin errors++; $display("FAIL rr_start_wait n=%0d got none exp start",
                                                    n); end
      exp_ss = 2'b11; exp_ss[exp % 2] = 1'b0;
      checks++; if (spi_data !== 8'h10 + 8'(exp) || ss_n !== exp_ss) begin errors++;
        $display("FAIL rr_order n=%0d got %h %b exp %h %b", n, spi_data, ss_n, 8'h10 + 8'(exp),
                 exp_ss); end
      if (n > 0) begin
        checks++; if (hi != int'(Gap) + 2) begin errors++;
          $display("FAIL rr_gap n=%0d got %0d exp %0d", n, hi, Gap + 2); end
      end
      tick;
      spi_done = 1'b1; spi_rx = 8'hC0 + 8'(exp);
      tick;
      spi_done = 1'b0;
      checks++; if (ack !== (4'b0001 << exp) || rsp_data !== 8'hC0 + 8'(exp)) begin errors++;
        $display("FAIL rr_ack n=%0d got %b %h exp %b %h", n, ack, rsp_data, 4'b0001 << exp,
                 8'hC0 + 8'(exp)); end
    end
    req = 4'b0;
    repeat (5) tick;
  endtask

  task automatic test_reset_busy;
    do_reset;
    req_slave[2] = 1'b0; req_slave[0] = 1'b0;
    req = 4'b0100;
    tick; tick; tick;
    checks++; if (ss_n !== 2'b10 || spi_data !== 8'h12) begin errors++;
      $display("FAIL rstb_busy got %b %h exp 10 12", ss_n, spi_data); end
    rst = 1'b0;
    tick;
    checks++; if (ss_n !== 2'b11 || ack !== 4'b0) begin errors++;
      $display("FAIL rstb_abort got %b %b exp 11 0000", ss_n, ack); end
    rst = 1'b1; req = 4'b0101;
    tick;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL rstb_no_ack got %b exp 0000", ack);
    end
    tick;
    checks++; if (spi_start !== 1'b1 || spi_data !== 8'h10) begin errors++;
      $display("FAIL rstb_regrant got %b %h exp 1 10", spi_start, spi_data); end
    tick;
    spi_done = 1'b1; spi_rx = 8'h5A;
    tick;
    spi_done = 1'b0;
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL rstb_ack got %b exp 0001", ack);
    end
    req = 4'b0;
    repeat (5) tick;
  endtask

  task automatic test_bad_slave;
    int bad;
    do_reset;
    bad = 0;
    req_data[7:0] = 8'h99; req_slave2 = 8'h03; req2 = 4'b0001;
    tick;
    if (spi_start2 !== 1'b0 || ss_n2 !== 3'b111) bad++;
    tick;
    if (spi_start2 !== 1'b0 || ss_n2 !== 3'b111 || ack2 !== 4'b0) bad++;
    tick;
    if (ss_n2 !== 3'b111) bad++;
    checks++; if (ack2 !== 4'b0001 || rsp_err2 !== 1'b1 || rsp_data2 !== 8'h00) begin errors++;
      $display("FAIL bad_slave_ack got %b %b %h exp 0001 1 00", ack2, rsp_err2, rsp_data2); end
    req2 = 4'b0;
    tick;
    if (ss_n2 !== 3'b111 || ack2 !== 4'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bad_slave_quiet got %0d bad exp 0", bad);
    end
    repeat (3) tick;
    req_slave2[3:2] = 2'd2; req2 = 4'b0010;
    tick; tick;
    checks++; if (spi_start2 !== 1'b1 || ss_n2 !== 3'b011) begin errors++;
      $display("FAIL top_slave_start got %b %b exp 1 011", spi_start2, ss_n2); end
    tick;
    spi_done = 1'b1; spi_rx = 8'hE1;
    tick;
    spi_done = 1'b0;
    checks++; if (ack2 !== 4'b0010 || rsp_err2 !== 1'b0 || rsp_data2 !== 8'hE1) begin errors++;
      $display("FAIL top_slave_ack got %b %b %h exp 0010 0 e1", ack2, rsp_err2, rsp_data2); end
    req2 = 4'b0;
    repeat (5) tick;
  endtask

  task automatic test_stray_done;
    do_reset;
    spi_done = 1'b1; spi_rx = 8'hFF;
    tick;
    spi_done = 1'b0;
    checks++; if (ack !== 4'b0 || ss_n !== 2'b11 || spi_start !== 1'b0) begin errors++;
      $display("FAIL stray_idle got %b %b %b exp 0000 11 0", ack, ss_n, spi_start); end
    req_data[31:24] = 8'h4D; req_slave[3] = 1'b1; req = 4'b1000;
    tick; tick;
    checks++; if (spi_start !== 1'b1 || spi_data !== 8'h4D) begin errors++;
      $display("FAIL stray_idle_latency got %b %h exp 1 4d", spi_start, spi_data); end
    tick;
    spi_done = 1'b1; spi_rx = 8'h21;
    tick;
    spi_done = 1'b0;
    checks++; if (ack !== 4'b1000 || rsp_data !== 8'h21) begin errors++;
      $display("FAIL stray_txn_ack got %b %h exp 1000 21", ack, rsp_data); end
    req = 4'b0;
    tick;
    spi_done = 1'b1; spi_rx = 8'hEE;
    tick;
    spi_done = 1'b0;
    checks++; if (ack !== 4'b0 || rsp_data !== 8'h21) begin errors++;
      $display("FAIL stray_gap got %b %h exp 0000 21", ack, rsp_data); end
    tick; tick;
    req_data[7:0] = 8'h3E; req = 4'b0001;
    tick;
    checks++; if (spi_start !== 1'b0) begin errors++;
      $display("FAIL stray_gap_grant got %b exp 0", spi_start); end
    tick;
    checks++; if (spi_start !== 1'b1 || spi_data !== 8'h3E) begin errors++;
      $display("FAIL stray_gap_latency got %b %h exp 1 3e", spi_start, spi_data); end
    tick;
    spi_done = 1'b1;
    tick;
    spi_done = 1'b0; req = 4'b0;
    repeat (5) tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req = '0; req2 = '0; req_data = 32'h1234_5678; req_mode = 8'hFF;
    req_slave = 4'hF; req_slave2 = 8'h00; spi_done = 1'b0; spi_rx = 8'h00;
    test_reset;
    test_single;
    test_timeout;
    test_timeout_edge;
    test_contention;
    test_reset_busy;
    test_bad_slave;
    test_stray_done;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
